rv_fetch_queue: RTL and testbench
=================================

# rv_fetch_queue

In-order instruction queue between the fetch stage and decode. It allocates an entry, tagged with the PC, when fetch issues an instruction-bus request. It fills that entry when the bus acknowledges with the instruction word, and presents completed entries to decode with a valid/ready handshake. On a redirect (branch/jump flush) it drops all queued entries and silently discards bus responses still in flight for the flushed requests.

## Interface
- DEPTH, 2, number of queue entries; power of two, ≥ 2
- NOP_INSTR, 32'h0000_0013, word driven on o_dec_instr when no valid entry is presented
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_flush  in  1  redirect; drop all entries and in-flight requests
- i_req_valid  in  1  fetch issued a bus request this cycle; legal only when o_req_ready=1
- i_req_pc  in  [31:2]  word PC of the issued request
- o_req_ready  out  1  queue can accept a new request (drives fetch pre-stall when low)
- i_bus_ack  in  1  instruction bus returns data for the oldest outstanding request
- i_bus_rdata  in  [31:0]  instruction word, qualified by i_bus_ack
- o_dec_valid  out  1  head entry filled and presented to decode
- i_dec_ready  in  1  decode accepts head this cycle
- o_dec_instr  out  [31:0]  head instruction word (NOP_INSTR when o_dec_valid=0)
- o_dec_pc  out  [31:2]  head PC (0 when o_dec_valid=0)

## Operation
- State:
  - circular storage of DEPTH entries {pc, instr, filled}
  - rd_ptr, alloc_ptr, fill_ptr (each log2(DEPTH) bits, wrapping modulo DEPTH)
  - count (allocated entries, 0..DEPTH)
  - discard (in-flight responses to drop, 0..DEPTH)
- Allocate: i_req_valid & o_req_ready writes {i_req_pc, filled=0} at alloc_ptr, alloc_ptr+1, count+1.
- Ack routing:
  - if discard>0, the ack is dropped and discard decrements;
  - otherwise rdata is written at fill_ptr, filled is set and fill_ptr increments.
  - An ack with discard=0 and no unfilled entry is a protocol error; it is ignored.
- Pop: o_dec_valid & i_dec_ready clears the head entry's filled bit, increments rd_ptr, count-1.
- o_req_ready = (count + discard) < DEPTH. There is no lookahead on same-cycle pop or ack.
- Flush (highest priority):
  - count, filled bits and the pointers reset to equal values (rd_ptr=alloc_ptr=fill_ptr); o_dec_valid is 0 next cycle.
  - discard_next = discard + unfilled + (i_req_valid & o_req_ready) − i_bus_ack, where unfilled = count − filled entries.
  - A request issued in the flush cycle is treated as stale.
  - A pop in the flush cycle still completes toward decode; decode qualifies it with its own flush.
- Simultaneous allocate + pop + ack in one cycle are all legal and all take effect.

## Timing
- Reset values: o_dec_valid=0, o_dec_instr=NOP_INSTR, o_dec_pc=0, o_req_ready=1, count=0, discard=0, all pointers 0.
- Latency ack → o_dec_valid: 1 cycle when the acked entry is the head (non-bypass build).
- Request → ack: any number of cycles ≥ 1. Responses return strictly in order.
- Outputs are combinational from registered state (plus i_bus_ack/i_bus_rdata in bypass build). There is no combinational path from i_dec_ready to any output.
- Reset mid-operation: all state returns to reset values. In-flight bus responses are the bus's responsibility (the bus is reset together).

## Configuration
- RV_FETCH_QUEUE_BYPASS_EN defined:
  - when the head entry is allocated but unfilled and i_bus_ack arrives with discard=0, o_dec_valid=1 in the same cycle;
  - o_dec_instr=i_bus_rdata and o_dec_pc=head pc;
  - if i_dec_ready, the entry is popped without its filled bit ever being set.
- Undefined: ack → o_dec_valid latency is exactly 1 cycle, with no combinational bus → decode path.

## Structure
- Shared package rv_pkg:
  - RV_NOP constant (32'h0000_0013), used as the NOP_INSTR default;
  - typedef fetch_entry_t {logic[31:2] pc; logic[31:0] instr; logic filled;}.
- Single module; no sub-module. Storage is a DEPTH-entry array of fetch_entry_t, pointer arithmetic inline.

## Test plan
- Basic flow: req pc 0x100>>2, ack 2 cycles later rdata 32'h00500093, i_dec_ready=1 → o_dec_valid next cycle with that instr and pc; o_dec_instr=32'h00000013 otherwise.
- Backpressure: DEPTH=2, two reqs acked, i_dec_ready=0 → o_req_ready=0, third req not accepted; one pop → o_req_ready=1 the following cycle.
- Flush with 2 outstanding unacked reqs → discard=2; req pc 0x200>>2 issued, three acks 0xAAAA0000, 0xBBBB0000, 0x00100113 → only 0x00100113 presented, pc 0x200>>2.
- Flush in the same cycle as an ack and a new req (1 unfilled before) → discard=1 after, next ack dropped, following ack presented.
- Simultaneous req + ack + pop at count=1 → count stays 1, pointers advance correctly over 8 wraps, order preserved.
- Bypass build: ack to unfilled head with i_dec_ready=1 → o_dec_valid=1 in the ack cycle, count decrements; non-bypass build → valid one cycle later.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path definitions.
//   RV_NOP        : canonical RISC-V NOP (addi x0, x0, 0), driven to decode when idle
//   fetch_entry_t : one fetch queue slot {word PC, instruction word, filled flag}
package rv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_queue.sv
// In-order instruction queue between fetch and decode.
// An entry is allocated (tagged with its PC) when fetch issues a bus request,
// filled when the bus acknowledges, and handed to decode with valid/ready.
// A flush drops every entry and arms a discard counter so that responses
// still in flight for the flushed requests are silently swallowed.
//
// Build option: define RV_FETCH_QUEUE_BYPASS_EN to forward an acknowledge that
// targets the unfilled head straight to decode in the same cycle.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_flush                   redirect: drop all entries and in-flight requests
//   i_req_valid, i_req_pc     fetch issued a bus request for word PC
//   o_req_ready               queue can take another request
//   i_bus_ack, i_bus_rdata    in-order bus response for oldest outstanding request
//   o_dec_valid, i_dec_ready  decode handshake on the head entry
//   o_dec_instr, o_dec_pc     head instruction / PC (NOP / 0 when not valid)
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_req_valid,
    input  logic [31:2] i_req_pc,
    output logic        o_req_ready,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_dec_instr,
    output logic [31:2] o_dec_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] discard;

    logic [CNT_W-1:0] filled_cnt;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] discard_flush;
    logic [SUM_W-1:0] occupancy;
    logic [SUM_W-1:0] stale_sum;
    fetch_entry_t     head;
    logic             alloc;
    logic             ack_drop;
    logic             ack_fill;
    logic             head_valid;
    logic             pop;

    // Entries fill strictly in order, so allocated-but-unfilled entries are
    // exactly those still awaiting a bus response.
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CNT_W'(entries[i].filled);
        end
    end

    assign unfilled = count - filled_cnt;
    assign head     = entries[rd_ptr];

    // Requests still in flight for flushed entries occupy slots until their
    // responses drain, so they count against capacity.
    assign occupancy   = SUM_W'(count) + SUM_W'(discard);
    assign o_req_ready = (occupancy < SUM_W'(DEPTH));

    assign alloc    = i_req_valid & o_req_ready;
    assign ack_drop = i_bus_ack & (discard != '0);
    // An ack with nothing outstanding is a protocol error and is ignored.
    assign ack_fill = i_bus_ack & (discard == '0) & (unfilled != '0);

    assign head_valid = (count != '0) & head.filled;

`ifdef RV_FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;

    // Unfilled head means fill_ptr == rd_ptr, so this ack belongs to the head.
    assign bypass_hit = ack_fill & (count != '0) & ~head.filled;

    always_comb begin
        o_dec_valid = head_valid | bypass_hit;
        o_dec_instr = NOP_INSTR;
        o_dec_pc    = '0;
        if (head_valid) begin
            o_dec_instr = head.instr;
            o_dec_pc    = head.pc;
        end else if (bypass_hit) begin
            o_dec_instr = i_bus_rdata;
            o_dec_pc    = head.pc;
        end
    end
`else
    always_comb begin
        o_dec_valid = head_valid;
        o_dec_instr = NOP_INSTR;
        o_dec_pc    = '0;
        if (head_valid) begin
            o_dec_instr = head.instr;
            o_dec_pc    = head.pc;
        end
    end
`endif

    assign pop = o_dec_valid & i_dec_ready;

    assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);

    // On flush every unfilled entry plus a request issued this cycle becomes a
    // stale in-flight response; an ack arriving this cycle retires one of them.
    always_comb begin
        stale_sum = SUM_W'(discard) + SUM_W'(unfilled) + SUM_W'(alloc);
        if (i_bus_ack && (stale_sum != '0)) begin
            stale_sum = stale_sum - SUM_W'(1);
        end
        discard_flush = CNT_W'(stale_sum);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr    <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            count     <= '0;
            discard   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else if (i_flush) begin
            rd_ptr    <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            count     <= '0;
            discard   <= discard_flush;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                entries[alloc_ptr].pc     <= i_req_pc;
                entries[alloc_ptr].filled <= 1'b0;
                alloc_ptr                 <= alloc_ptr + PTR_W'(1);
            end
            if (ack_drop) begin
                discard <= discard - CNT_W'(1);
            end
            if (ack_fill) begin
                entries[fill_ptr].instr  <= i_bus_rdata;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PTR_W'(1);
            end
            // Placed after the fill so a bypassed head that is popped in its
            // ack cycle never ends up marked filled.
            if (pop) begin
                entries[rd_ptr].filled <= 1'b0;
                rd_ptr                 <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
module tb_rv_fetch_queue;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_req_valid;
    logic [31:2] i_req_pc;
    logic        o_req_ready;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_dec_valid;
    logic        i_dec_ready;
    logic [31:0] o_dec_instr;
    logic [31:2] o_dec_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv_fetch_queue #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_flush),
        .i_req_valid (i_req_valid),
        .i_req_pc    (i_req_pc),
        .o_req_ready (o_req_ready),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_dec_valid (o_dec_valid),
        .i_dec_ready (i_dec_ready),
        .o_dec_instr (o_dec_instr),
        .o_dec_pc    (o_dec_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:2] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:2] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Apply inputs for one cycle, then return to idle (dec_ready persists).
    task automatic drive(input logic req, input logic [31:2] pc, input logic ack,
                         input logic [31:0] rd, input logic rdy, input logic fl);
        i_req_valid = req;
        i_req_pc    = pc;
        i_bus_ack   = ack;
        i_bus_rdata = rd;
        i_dec_ready = rdy;
        i_flush     = fl;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_req_pc    = '0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        i_flush     = 1'b0;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    // Scoreboard monitor: every accepted decode transfer pops one expectation.
    always @(negedge i_clk) begin
        if (i_reset_n && o_dec_valid && i_dec_ready) begin
            check("queue_nonempty_on_pop", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("dec_pc", {34'd0, o_dec_pc}, {34'd0, e.pc});
                check("dec_instr", {32'd0, o_dec_instr}, {32'd0, e.instr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset_n   = 1'b0;
        i_flush     = 1'b0;
        i_req_valid = 1'b0;
        i_req_pc    = '0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        i_dec_ready = 1'b0;
        idle(1'b0, 2);

        // Reset state
        check("rst_dec_valid", {63'd0, o_dec_valid}, 64'd0);
        check("rst_dec_instr", {32'd0, o_dec_instr}, {32'd0, NOP});
        check("rst_dec_pc", {34'd0, o_dec_pc}, 64'd0);
        check("rst_req_ready", {63'd0, o_req_ready}, 64'd1);
        i_reset_n = 1'b1;

        // Basic flow: pc 0x100, ack two cycles later
        drive(1'b1, 30'h40, 1'b0, '0, 1'b1, 1'b0);
        idle(1'b1, 1);
        check("basic_pre_valid", {63'd0, o_dec_valid}, 64'd0);
        check("basic_pre_instr", {32'd0, o_dec_instr}, {32'd0, NOP});
        push_exp(30'h40, 32'h0050_0093);
        drive(1'b0, '0, 1'b1, 32'h0050_0093, 1'b1, 1'b0);
        idle(1'b1, 2);
        check("basic_post_valid", {63'd0, o_dec_valid}, 64'd0);
        check("basic_post_instr", {32'd0, o_dec_instr}, {32'd0, NOP});

        // Backpressure with DEPTH=2
        drive(1'b1, 30'h50, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 30'h51, 1'b0, '0, 1'b0, 1'b0);
        check("bp_full_ready", {63'd0, o_req_ready}, 64'd0);
        push_exp(30'h50, 32'h1111_1111);
        drive(1'b0, '0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        push_exp(30'h51, 32'h2222_2222);
        drive(1'b0, '0, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        check("bp_filled_ready", {63'd0, o_req_ready}, 64'd0);
        drive(1'b1, 30'h52, 1'b0, '0, 1'b0, 1'b0);   // must be refused
        check("bp_head_valid", {63'd0, o_dec_valid}, 64'd1);
        check("bp_head_pc", {34'd0, o_dec_pc}, 64'h50);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);       // one pop
        check("bp_ready_after_pop", {63'd0, o_req_ready}, 64'd1);
        idle(1'b1, 2);
        check("bp_drained_valid", {63'd0, o_dec_valid}, 64'd0);

        // Flush with two outstanding unacked requests
        drive(1'b1, 30'h60, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 30'h61, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check("fl2_ready_disc2", {63'd0, o_req_ready}, 64'd0);
        check("fl2_valid", {63'd0, o_dec_valid}, 64'd0);
        drive(1'b0, '0, 1'b1, 32'hAAAA_0000, 1'b1, 1'b0);
        check("fl2_ready_disc1", {63'd0, o_req_ready}, 64'd1);
        drive(1'b1, 30'h80, 1'b0, '0, 1'b1, 1'b0);
        check("fl2_ready_busy", {63'd0, o_req_ready}, 64'd0);
        drive(1'b0, '0, 1'b1, 32'hBBBB_0000, 1'b1, 1'b0);
        check("fl2_dropped_valid", {63'd0, o_dec_valid}, 64'd0);
        check("fl2_ready_disc0", {63'd0, o_req_ready}, 64'd1);
        push_exp(30'h80, 32'h0010_0113);
        drive(1'b0, '0, 1'b1, 32'h0010_0113, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Flush coinciding with ack and new request, one unfilled before
        drive(1'b1, 30'h90, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 30'h91, 1'b1, 32'hCCCC_0000, 1'b0, 1'b1);
        check("flx_valid", {63'd0, o_dec_valid}, 64'd0);
        check("flx_ready_disc1", {63'd0, o_req_ready}, 64'd1);
        drive(1'b1, 30'h92, 1'b0, '0, 1'b0, 1'b0);
        check("flx_ready_busy", {63'd0, o_req_ready}, 64'd0);
        drive(1'b0, '0, 1'b1, 32'hDDDD_0000, 1'b0, 1'b0);
        check("flx_dropped_valid", {63'd0, o_dec_valid}, 64'd0);
        push_exp(30'h92, 32'h0020_0213);
        drive(1'b0, '0, 1'b1, 32'h0020_0213, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Overlapped request/ack/pop across 8 pointer wraps
        drive(1'b1, 30'h100, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            push_exp(30'h100 + 30'(k), 32'h1000_0000 + 32'(k) * 32'h111);
            drive(k < 15, 30'h100 + 30'(k + 1), 1'b1,
                  32'h1000_0000 + 32'(k) * 32'h111, 1'b1, 1'b0);
            idle(1'b1, 1);
        end
        idle(1'b1, 2);
        check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
        check("wrap_valid", {63'd0, o_dec_valid}, 64'd0);
        check("wrap_ready", {63'd0, o_req_ready}, 64'd1);

        // Ack-to-decode latency on the head entry
        drive(1'b1, 30'hA0, 1'b0, '0, 1'b1, 1'b0);
        push_exp(30'hA0, 32'h0030_0313);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h0030_0313;
        #1;
`ifdef RV_FETCH_QUEUE_BYPASS_EN
        check("lat_ack_cycle_valid", {63'd0, o_dec_valid}, 64'd1);
        check("lat_ack_cycle_instr", {32'd0, o_dec_instr}, 64'h0030_0313);
        check("lat_ack_cycle_pc", {34'd0, o_dec_pc}, 64'hA0);
        @(posedge i_clk);
        #1;
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        check("lat_next_valid", {63'd0, o_dec_valid}, 64'd0);
        check("lat_next_ready", {63'd0, o_req_ready}, 64'd1);
`else
        check("lat_ack_cycle_valid", {63'd0, o_dec_valid}, 64'd0);
        @(posedge i_clk);
        #1;
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        check("lat_next_valid", {63'd0, o_dec_valid}, 64'd1);
        check("lat_next_instr", {32'd0, o_dec_instr}, 64'h0030_0313);
`endif
        idle(1'b1, 2);
        check("lat_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation with a filled entry waiting
        drive(1'b1, 30'hB0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("mid_pre_valid", {63'd0, o_dec_valid}, 64'd1);
        i_reset_n = 1'b0;
        idle(1'b0, 1);
        i_reset_n = 1'b1;
        check("mid_rst_valid", {63'd0, o_dec_valid}, 64'd0);
        check("mid_rst_instr", {32'd0, o_dec_instr}, {32'd0, NOP});
        check("mid_rst_pc", {34'd0, o_dec_pc}, 64'd0);
        check("mid_rst_ready", {63'd0, o_req_ready}, 64'd1);
        idle(1'b1, 2);
        check("final_valid", {63'd0, o_dec_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
